// File: rtl/udp_tx_framer.sv
// udp_tx_framer: prepends Ethernet, IP and UDP header beats to a 64-bit
// payload stream. Payload beats pass through with no added latency.
module udp_tx_framer #(
    parameter int          DATA_W    = 64,
    parameter logic [47:0] DST_MAC   = 48'h01005E010101,
    parameter logic [15:0] ETHERTYPE = 16'h0800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [31:0]       hdr_ip_src,
    input  logic [31:0]       hdr_ip_dst,
    input  logic [15:0]       hdr_udp_sport,
    input  logic [15:0]       hdr_udp_dport,
    input  logic [15:0]       hdr_pay_len,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              len_err,
    output logic [31:0]       frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ETH,
        S_IP,
        S_UDP,
        S_PAY
    } state_t;

    state_t state_q, state_d;

    logic [31:0] ip_src_q;
    logic [31:0] ip_dst_q;
    logic [15:0] sport_q;
    logic [15:0] dport_q;
    logic [15:0] pay_len_q;

    logic [15:0] beat_cnt_q;
    logic        err_seen_q;
    logic        len_err_q;
    logic [31:0] frame_count_q;

    logic        hdr_acc;
    logic        pay_hs;
    logic        frame_done;
    logic        err_hit;

    logic [15:0] udp_len;
    logic [16:0] len_plus7;
    logic [15:0] exp_beats;
    logic [15:0] beat_num;

    // UDP length wraps at 16 bits; expected beat count is ceil(len/8)
    assign udp_len   = pay_len_q + 16'd8;
    assign len_plus7 = {1'b0, pay_len_q} + 17'd7;
    assign exp_beats = {2'b00, len_plus7[16:3]};
    assign beat_num  = beat_cnt_q + 16'd1;

    assign len_err     = len_err_q;
    assign frame_count = frame_count_q;

    // Length mismatch: early tlast, or the expected last beat lacks tlast
    always_comb begin
        err_hit = 1'b0;
        if (pay_hs && !err_seen_q) begin
            if (s_axis_tlast && (beat_num < exp_beats)) begin
                err_hit = 1'b1;
            end else if (!s_axis_tlast && (beat_num == exp_beats)) begin
                err_hit = 1'b1;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        hdr_ready     = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        hdr_acc       = 1'b0;
        pay_hs        = 1'b0;
        frame_done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                hdr_ready = 1'b1;
                if (hdr_valid) begin
                    hdr_acc = 1'b1;
                    state_d = S_ETH;
                end
            end
            S_ETH: begin
                m_axis_tdata  = {DST_MAC, ETHERTYPE};
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    state_d = S_IP;
                end
            end
            S_IP: begin
                m_axis_tdata  = {ip_src_q, ip_dst_q};
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    state_d = S_UDP;
                end
            end
            S_UDP: begin
                m_axis_tdata  = {sport_q, dport_q, udp_len, 16'h0000};
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (pay_len_q == 16'd0);
                if (m_axis_tready) begin
                    if (pay_len_q == 16'd0) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
                pay_hs        = s_axis_tvalid && m_axis_tready;
                if (pay_hs && s_axis_tlast) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the descriptor on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_src_q  <= '0;
            ip_dst_q  <= '0;
            sport_q   <= '0;
            dport_q   <= '0;
            pay_len_q <= '0;
        end else if (hdr_acc) begin
            ip_src_q  <= hdr_ip_src;
            ip_dst_q  <= hdr_ip_dst;
            sport_q   <= hdr_udp_sport;
            dport_q   <= hdr_udp_dport;
            pay_len_q <= hdr_pay_len;
        end
    end

    // Payload beat counter and once-per-frame length error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            err_seen_q <= 1'b0;
        end else if (hdr_acc) begin
            beat_cnt_q <= '0;
            err_seen_q <= 1'b0;
        end else if (pay_hs) begin
            beat_cnt_q <= beat_num;
            if (err_hit) begin
                err_seen_q <= 1'b1;
            end
        end
    end

    // One-cycle length error pulse, the cycle after the offending beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= err_hit;
        end
    end

    // Completed frame counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= '0;
        end else if (frame_done) begin
            frame_count_q <= frame_count_q + 32'd1;
        end
    end

endmodule
